shift_rows_stream: RTL

- Parametrised, pipelined Rijndael ShiftRows stage with a valid/ready stream interface.
- Generalises the fixed 128-bit AES permutation:
  - block width NB columns (4/6/8 words, Rijndael offsets);
  - per-beat forward/inverse mode;
  - registered output with a 2-entry skid buffer for full throughput under backpressure.
- Sits between SubBytes and MixColumns stages in the round datapath; inverse mode serves the decryption path.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/rijndael_shift_perm.sv | 31 +++
 rtl/shift_rows_stream.sv | 115 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: row shift offsets, byte indexing and
// the occupancy states of the ShiftRows skid buffer.
package aes_pkg;

  localparam int NB_MAX = 8;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_t;

  // Rijndael offsets: {0,1,2,3} up to 6 columns, {0,1,3,4} at 8.
  function automatic int shift_off(input int nb, input int row);
    if (nb == 8 && row >= 2) return row + 1;
    return row;
  endfunction

  function automatic int byte_idx(input int row, input int col);
    return 4 * col + row;
  endfunction

endpackage

// File: rtl/rijndael_shift_perm.sv
// Combinational Rijndael (Inv)ShiftRows byte permutation for an
// NB-column state; pure wiring plus one 2:1 mux per byte.
module rijndael_shift_perm
  import aes_pkg::*;
#(
  parameter int NB = 4,
  localparam int SW = 32 * NB
) (
  input  logic [SW-1:0] state,
  input  logic          inv,
  output logic [SW-1:0] perm
);

  if (!(NB == 4 || NB == 6 || NB == 8) || NB > NB_MAX) begin : g_bad_nb
    $error("rijndael_shift_perm: NB must be 4, 6 or 8");
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int S  = shift_off(NB, r);
      localparam int FC = (c + S) % NB;
      localparam int IC = (c + NB - S) % NB;
      localparam int D  = SW - 1 - 8 * byte_idx(r, c);
      localparam int FS = SW - 1 - 8 * byte_idx(r, FC);
      localparam int IS = SW - 1 - 8 * byte_idx(r, IC);

      assign perm[D -: 8] = inv ? state[IS -: 8] : state[FS -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Pipelined ShiftRows stage: permute on entry, then a registered
// main slot plus skid slot for full throughput under backpressure.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int NB = 4,
  localparam int SW = 32 * NB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_state,
  input  logic          in_inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_state,
  output logic          out_inv
);

  skid_state_t state, nxt;

  logic          accept;
  logic          drain;
  logic          load_m;
  logic          load_s;
  logic          m_from_s;
  logic [SW-1:0] perm;
  logic [SW-1:0] m_state;
  logic [SW-1:0] s_state;
  logic          m_inv;
  logic          s_inv;

  rijndael_shift_perm #(
    .NB(NB)
  ) u_perm (
    .state(in_state),
    .inv  (in_inv),
    .perm (perm)
  );

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_comb begin
    nxt      = state;
    load_m   = 1'b0;
    load_s   = 1'b0;
    m_from_s = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          nxt    = ONE;
          load_m = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_m = 1'b1;
        end else if (accept) begin
          nxt    = FULL;
          load_s = 1'b1;
        end else if (drain) begin
          nxt = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          nxt      = ONE;
          m_from_s = 1'b1;
        end
      end
      default: nxt = EMPTY;
    endcase
  end

  // Handshake outputs are flops fed from next state, so neither
  // side sees a combinational path from the other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= nxt;
      in_ready  <= (nxt != FULL);
      out_valid <= (nxt != EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= '0;
      m_inv   <= 1'b0;
      s_state <= '0;
      s_inv   <= 1'b0;
    end else begin
      if (load_m) begin
        m_state <= perm;
        m_inv   <= in_inv;
      end else if (m_from_s) begin
        m_state <= s_state;
        m_inv   <= s_inv;
      end
      if (load_s) begin
        s_state <= perm;
        s_inv   <= in_inv;
      end
    end
  end

  assign out_state = m_state;
  assign out_inv   = m_inv;

endmodule
